dot_prod_seq_ctrl: RTL and testbench

- Sequencer that computes an N-element two-lane dot product, sum over k of (a_k*b_k + c_k*d_k), by streaming operand beats through one shared two-term multiply-add stage into a wide accumulator.
- Sits between an operand-fetch stream (valid/ready) and a result consumer (valid/ready).
- A start/len command sets the vector length; the result is held until the consumer accepts it.

---
 rtl/dot_prod_seq_ctrl.sv | 119 +++++++++++
 tb/tb_dot_prod_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_prod_seq_ctrl.sv
// Streams len beats of (a,b,c,d) through one two-term multiply-add into a wide
// accumulator, then holds sum(a*b + c*d) on res until the consumer takes it.
module dot_prod_seq_ctrl #(
    parameter int BW    = 8,
    parameter int LEN_W = 8,
    parameter int ACC_W = 2*BW+LEN_W+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BW-1:0]    a,
    input  logic [BW-1:0]    b,
    input  logic [BW-1:0]    c,
    input  logic [BW-1:0]    d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] res,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [ACC_W-1:0]   res_n;
    logic [2*BW-1:0]    p_ab, p_cd;
    logic [ACC_W-1:0]   sum;

    // Both streams transfer only in a cycle where valid && ready; the producer
    // must hold its data stable while valid is high and ready is low.
    assign in_ready  = (state == RUN);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    assign p_ab = a * b;
    assign p_cd = c * d;
    assign sum  = acc + ACC_W'(p_ab) + ACC_W'(p_cd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            res   <= '0;
        end else begin
            acc   <= acc_n;
            cnt   <= cnt_n;
            len_q <= len_n;
            res   <= res_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        len_n   = len_q;
        res_n   = res;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_n = '0;
                    cnt_n = '0;
                    if (len != '0) begin
                        len_n   = len;
                        state_n = RUN;
                    end else begin
                        res_n   = '0;
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                // Abort wins over a same-cycle beat; that beat is dropped.
                if (abort) begin
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (in_valid) begin
                    acc_n = sum;
                    cnt_n = cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1)) begin
                        res_n   = sum;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dot_prod_seq_ctrl.sv
// Directed bench for dot_prod_seq_ctrl: a vector table for the main flows plus
// hand-written sequences for the full-length run and an asynchronous reset.
module tb_dot_prod_seq_ctrl;
    localparam int BW    = 8;
    localparam int LEN_W = 8;
    localparam int ACC_W = 2*BW+LEN_W+1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [BW-1:0]    a, b, c, d;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] res;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] exp_q[$];

    dot_prod_seq_ctrl #(.BW(BW), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             start;
        logic [LEN_W-1:0] len;
        logic             abort;
        logic             in_valid;
        logic [BW-1:0]    a, b, c, d;
        logic             out_ready;
        logic             e_busy;
        logic             e_in_ready;
        logic             e_out_valid;
        logic [ACC_W-1:0] e_res;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input int ln, input logic ab, input logic iv,
                                input int va, input int vb, input int vc, input int vd,
                                input logic ordy, input logic eb, input logic eir,
                                input logic eov, input int er);
        vec_t v;
        v.start = st;  v.len = LEN_W'(ln); v.abort = ab; v.in_valid = iv;
        v.a = BW'(va); v.b = BW'(vb); v.c = BW'(vc); v.d = BW'(vd);
        v.out_ready = ordy; v.e_busy = eb; v.e_in_ready = eir;
        v.e_out_valid = eov; v.e_res = ACC_W'(er);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic eb, input logic eir,
                              input logic eov, input logic [ACC_W-1:0] er);
        check({tag, ".busy"},      32'(busy),      32'(eb));
        check({tag, ".in_ready"},  32'(in_ready),  32'(eir));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        check({tag, ".res"},       32'(res),       32'(er));
    endtask

    // driver
    task automatic drive(input logic st, input int ln, input logic ab, input logic iv,
                         input int va, input int vb, input int vc, input int vd,
                         input logic ordy);
        start = st; len = LEN_W'(ln); abort = ab; in_valid = iv;
        a = BW'(va); b = BW'(vb); c = BW'(vc); d = BW'(vd);
        out_ready = ordy;
    endtask

    // scoreboard: every result handshake must match the next expected value
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got res %0d expected no result", res);
            end else begin
                logic [ACC_W-1:0] e;
                e = exp_q.pop_front();
                if (res !== e) begin
                    errors++;
                    $display("FAIL sb_res: got %0d expected %0d", res, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_outs("in_reset", 0, 0, 0, 0);
        rst = 1'b0;

        // reset then idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_outs($sformatf("idle%0d", i), 0, 0, 0, 0);
        end

        // basic 3-beat
        vecs.push_back(mk(1, 3, 0, 0,   0,   0,   0,   0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,   1,   2,   3,   4, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,   5,   6,   7,   8, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 255, 255, 255, 255, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 1,  1, 0, 1, 130150));
        // stalls and backpressure; start/abort in DONE and at handshake ignored
        vecs.push_back(mk(1, 2, 0, 0,   0,   0,   0,   0, 0,  0, 0, 0, 130150));
        vecs.push_back(mk(0, 0, 0, 1,   2,   3,   0,   0, 0,  1, 1, 0, 130150));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 0,  1, 1, 0, 130150));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 0,  1, 1, 0, 130150));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 0,  1, 1, 0, 130150));
        vecs.push_back(mk(0, 0, 0, 1,   0,   0,   4,   4, 0,  1, 1, 0, 130150));
        vecs.push_back(mk(1, 5, 0, 0,   0,   0,   0,   0, 0,  1, 0, 1, 22));
        vecs.push_back(mk(0, 0, 1, 1,   9,   9,   9,   9, 0,  1, 0, 1, 22));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 0,  1, 0, 1, 22));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 0,  1, 0, 1, 22));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 0,  1, 0, 1, 22));
        vecs.push_back(mk(1, 3, 0, 0,   0,   0,   0,   0, 1,  1, 0, 1, 22));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 0,  0, 0, 0, 22));
        // zero length
        vecs.push_back(mk(1, 0, 0, 0,   0,   0,   0,   0, 0,  0, 0, 0, 22));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0,   0,   0,   0,   0, 0,  0, 0, 0, 0));
        // abort with a simultaneous third beat, then a fresh 1-beat run
        vecs.push_back(mk(1, 4, 0, 0,   0,   0,   0,   0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  10,  10,  10,  10, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  10,  10,  10,  10, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1,   9,   9,   9,   9, 0,  1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,   0,   0,   0,   0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,   1,   1,   1,   1, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,   0,   0,   0,   0, 0,  1, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 1,  1, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,   0,   0, 0,  0, 0, 0, 2));

        exp_q.push_back(ACC_W'(130150));
        exp_q.push_back(ACC_W'(22));
        exp_q.push_back(ACC_W'(0));
        exp_q.push_back(ACC_W'(2));

        foreach (vecs[i]) begin
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_in_ready,
                       vecs[i].e_out_valid, vecs[i].e_res);
            drive(vecs[i].start, int'(vecs[i].len), vecs[i].abort, vecs[i].in_valid,
                  int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].c), int'(vecs[i].d),
                  vecs[i].out_ready);
        end

        // max-length, max-value run
        @(negedge clk);
        check_outs("max_idle", 0, 0, 0, 2);
        drive(1, 255, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(ACC_W'(33162750));
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            check($sformatf("max_in_ready%0d", k), 32'(in_ready), 32'd1);
            drive(0, 0, 0, 1, 255, 255, 255, 255, 0);
        end
        @(negedge clk);
        check_outs("max_done", 1, 0, 1, ACC_W'(33162750));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check_outs("max_after", 0, 0, 0, ACC_W'(33162750));
        drive(1, 255, 0, 0, 0, 0, 0, 0, 0);

        // same run, async reset mid-RUN at beat 100
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 1, 255, 255, 255, 255, 0);
        end
        @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_outs("rst_async", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 1, 255, 255, 255, 255, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_outs($sformatf("post_rst%0d", i), 0, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending: got %0d results outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
